// File: rtl/pkt_pkg.sv
// Shared types and width helpers for the packet slot allocator.
package pkt_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Bits needed to index n items, never less than one.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return idx_w(n) + 1;
    endfunction

endpackage

// File: rtl/pkt_row_ffs.sv
// Lowest-free-slot finder for one row of the occupancy bitmap (0 = free).
module pkt_row_ffs
    import pkt_pkg::*;
#(
    parameter int ROW_SLOTS = 8
)
(
    input  logic [ROW_SLOTS-1:0]          occ,
    output logic                          found,
    output logic [idx_w(ROW_SLOTS)-1:0]   slot
);

    localparam int SLOT_W = idx_w(ROW_SLOTS);

    // Scan downward so the last hit written is the lowest free index.
    always_comb begin
        found = 1'b0;
        slot  = '0;
        for (int i = ROW_SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                found = 1'b1;
                slot  = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/pkt_slot_alloc.sv
// Packet slot allocator: bitmap of NUM_ROWS x ROW_SLOTS slots, keyed home row,
// row-per-cycle flush. Define PKT_SLOT_ALLOC_SPILL_EN to spill into later rows.
module pkt_slot_alloc
    import pkt_pkg::*;
#(
    parameter int NUM_ROWS  = 8,
    parameter int ROW_SLOTS = 8,
    parameter int KEY_W     = 16
)
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  alloc_valid,
    input  logic [KEY_W-1:0]                      alloc_key,
    output logic                                  alloc_ready,
    output logic                                  rsp_valid,
    output logic                                  rsp_ok,
    output logic [idx_w(NUM_ROWS*ROW_SLOTS)-1:0]  rsp_idx,
    input  logic                                  free_valid,
    input  logic [idx_w(NUM_ROWS*ROW_SLOTS)-1:0]  free_idx,
    input  logic                                  flush,
    output logic [idx_w(NUM_ROWS*ROW_SLOTS):0]    used_cnt
);

    localparam int TOTAL  = NUM_ROWS * ROW_SLOTS;
    localparam int IDX_W  = idx_w(TOTAL);
    localparam int CNT_W  = cnt_w(TOTAL);
    localparam int ROW_W  = idx_w(NUM_ROWS);
    localparam int SLOT_W = idx_w(ROW_SLOTS);

    state_t                 state_reg, state_next;
    logic [ROW_W-1:0]       flush_row_reg, flush_row_next;
    logic [ROW_SLOTS-1:0]   occ_reg  [NUM_ROWS];
    logic [ROW_SLOTS-1:0]   occ_next [NUM_ROWS];
    logic [CNT_W-1:0]       used_cnt_reg, used_cnt_next;
    logic                   alloc_ready_reg;
    logic                   rsp_valid_reg, rsp_ok_reg;
    logic [IDX_W-1:0]       rsp_idx_reg;

    logic                   row_found [NUM_ROWS];
    logic [SLOT_W-1:0]      row_slot  [NUM_ROWS];

    generate
        for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            pkt_row_ffs #(.ROW_SLOTS(ROW_SLOTS)) u_ffs (
                .occ   (occ_reg[gi]),
                .found (row_found[gi]),
                .slot  (row_slot[gi])
            );
        end
    endgenerate

    logic [ROW_W-1:0]   home_row, hit_row, cand_row;
    logic [SLOT_W-1:0]  hit_slot;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;

    assign home_row = alloc_key[ROW_W-1:0];

    always_comb begin
        hit      = 1'b0;
        hit_row  = home_row;
        hit_slot = '0;
        cand_row = home_row;
`ifdef PKT_SLOT_ALLOC_SPILL_EN
        // Walk from the farthest row back to home so the nearest hit wins.
        for (int k = NUM_ROWS - 1; k >= 0; k--) begin
            cand_row = ROW_W'(int'(home_row) + k);
            if (row_found[cand_row]) begin
                hit      = 1'b1;
                hit_row  = cand_row;
                hit_slot = row_slot[cand_row];
            end
        end
`else
        hit      = row_found[home_row];
        hit_slot = row_slot[home_row];
`endif
    end

    assign hit_idx = IDX_W'(int'(hit_row) * ROW_SLOTS + int'(hit_slot));

    logic [ROW_W-1:0]   free_row;
    logic [SLOT_W-1:0]  free_slot;
    logic               free_in_range, free_eff, accept, alloc_do;

    assign free_row      = ROW_W'(int'(free_idx) / ROW_SLOTS);
    assign free_slot     = SLOT_W'(int'(free_idx) % ROW_SLOTS);
    assign free_in_range = int'(free_idx) < TOTAL;
    assign free_eff      = (state_reg == RUN) && free_valid && free_in_range
                           && occ_reg[free_row][free_slot];
    assign accept        = alloc_valid && alloc_ready_reg;
    assign alloc_do      = accept && hit;

    always_comb begin
        state_next     = state_reg;
        flush_row_next = flush_row_reg;
        occ_next       = occ_reg;
        used_cnt_next  = used_cnt_reg;
        if (state_reg == RUN) begin
            // Search above used the pre-free bitmap, so these never collide.
            if (free_eff)
                occ_next[free_row][free_slot] = 1'b0;
            if (alloc_do)
                occ_next[hit_row][hit_slot] = 1'b1;
            used_cnt_next = used_cnt_reg + {{(CNT_W-1){1'b0}}, alloc_do}
                                         - {{(CNT_W-1){1'b0}}, free_eff};
            if (flush) begin
                state_next     = FLUSH;
                flush_row_next = '0;
            end
        end else begin
            occ_next[flush_row_reg] = '0;
            if (flush_row_reg == ROW_W'(NUM_ROWS - 1)) begin
                state_next    = RUN;
                used_cnt_next = '0;
            end else begin
                flush_row_next = flush_row_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= RUN;
            flush_row_reg   <= '0;
            for (int r = 0; r < NUM_ROWS; r++)
                occ_reg[r] <= '0;
            used_cnt_reg    <= '0;
            alloc_ready_reg <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_ok_reg      <= 1'b0;
            rsp_idx_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            flush_row_reg   <= flush_row_next;
            occ_reg         <= occ_next;
            used_cnt_reg    <= used_cnt_next;
            alloc_ready_reg <= (state_next == RUN);
            rsp_valid_reg   <= accept;
            rsp_ok_reg      <= alloc_do;
            rsp_idx_reg     <= alloc_do ? hit_idx : '0;
        end
    end

    assign alloc_ready = alloc_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_ok      = rsp_ok_reg;
    assign rsp_idx     = rsp_idx_reg;
    assign used_cnt    = used_cnt_reg;

endmodule

// File: tb/tb_pkt_slot_alloc.sv
// Directed and randomized bench for pkt_slot_alloc against a slot-array reference model.
module tb_pkt_slot_alloc;

    localparam int NR  = 8;
    localparam int RS  = 8;
    localparam int TOT = NR * RS;
`ifdef PKT_SLOT_ALLOC_SPILL_EN
    localparam bit SPILL = 1'b1;
`else
    localparam bit SPILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [15:0] alloc_key = '0;
    logic        free_valid = 1'b0;
    logic [5:0]  free_idx = '0;
    logic        flush = 1'b0;
    logic        alloc_ready, rsp_valid, rsp_ok;
    logic [5:0]  rsp_idx;
    logic [6:0]  used_cnt;

    pkt_slot_alloc #(.NUM_ROWS(NR), .ROW_SLOTS(RS), .KEY_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_key   (alloc_key),
        .alloc_ready (alloc_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ok      (rsp_ok),
        .rsp_idx     (rsp_idx),
        .free_valid  (free_valid),
        .free_idx    (free_idx),
        .flush       (flush),
        .used_cnt    (used_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one flag per slot, a running count, flush rows left.
    bit m_occ [TOT];
    int m_cnt;
    int m_flush_left;
    bit m_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TOT; i++) m_occ[i] = 1'b0;
        m_cnt        = 0;
        m_flush_left = 0;
        m_ready      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_ok", 32'(rsp_ok), 0);
        check("rst_rsp_idx", 32'(rsp_idx), 0);
        check("rst_used_cnt", 32'(used_cnt), 0);
        check("rst_alloc_ready", 32'(alloc_ready), 0);
        $display("reset: outputs checked while rst high");
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // One clock of stimulus; the model predicts outputs after the edge.
    task automatic cycle(input bit av, input int key, input bit fv, input int fidx, input bit fl);
        bit acc, ok, fe, in_run;
        int idx, home, r, base;
        alloc_valid = av;
        alloc_key   = key[15:0];
        free_valid  = fv;
        free_idx    = fidx[5:0];
        flush       = fl;
        in_run = (m_flush_left == 0);
        acc    = av && m_ready;
        ok     = 1'b0;
        idx    = 0;
        if (acc) begin
            home = key % NR;
            for (int k = 0; k < (SPILL ? NR : 1) && !ok; k++) begin
                r = (home + k) % NR;
                for (int s = 0; s < RS && !ok; s++) begin
                    if (!m_occ[r*RS + s]) begin
                        ok  = 1'b1;
                        idx = r*RS + s;
                    end
                end
            end
        end
        fe = in_run && fv && (fidx < TOT) && m_occ[fidx];
        if (fe) begin
            m_occ[fidx] = 1'b0;
            m_cnt--;
        end
        if (ok) begin
            m_occ[idx] = 1'b1;
            m_cnt++;
        end
        if (in_run) begin
            if (fl) m_flush_left = NR;
        end else begin
            base = (NR - m_flush_left) * RS;
            for (int s = 0; s < RS; s++) m_occ[base + s] = 1'b0;
            m_flush_left--;
            if (m_flush_left == 0) m_cnt = 0;
        end
        m_ready = (m_flush_left == 0);
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(acc));
        if (acc) begin
            check("rsp_ok", 32'(rsp_ok), 32'(ok));
            check("rsp_idx", 32'(rsp_idx), 32'(idx));
        end
        check("used_cnt", 32'(used_cnt), 32'(m_cnt));
        check("alloc_ready", 32'(alloc_ready), 32'(m_ready));
        $display("cycle av=%0d key=%0d fv=%0d fidx=%0d fl=%0d -> rv=%0d ok=%0d idx=%0d cnt=%0d rdy=%0d",
                 av, key, fv, fidx, fl, rsp_valid, rsp_ok, rsp_idx, used_cnt, alloc_ready);
        alloc_valid = 1'b0;
        free_valid  = 1'b0;
        flush       = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // Reset release and first allocation into row 3.
        cycle(0, 0, 0, 0, 0);
        check("ready_after_rst", 32'(alloc_ready), 1);
        cycle(1, 3, 0, 0, 0);
        check("req044_ok", 32'(rsp_ok), 1);
        check("req044_idx", 32'(rsp_idx), 24);
        check("req044_cnt", 32'(used_cnt), 1);

        // Fill row 5, then a ninth request.
        for (int i = 0; i < 8; i++) cycle(1, 5, 0, 0, 0);
        cycle(1, 5, 0, 0, 0);
        if (SPILL) begin
            check("req045_spill_ok", 32'(rsp_ok), 1);
            check("req045_spill_idx", 32'(rsp_idx), 48);
        end else begin
            check("req045_ok", 32'(rsp_ok), 0);
            check("req045_idx", 32'(rsp_idx), 0);
        end

        // Row 3 full, simultaneous free of 26 and allocation to row 3.
        do_reset();
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 3, 0, 0, 0);
        cycle(1, 3, 1, 26, 0);
        if (SPILL) begin
            check("req046_spill_idx", 32'(rsp_idx), 32);
            check("req046_spill_cnt", 32'(used_cnt), 8);
        end else begin
            check("req046_ok", 32'(rsp_ok), 0);
            check("req046_cnt", 32'(used_cnt), 7);
        end
        cycle(1, 3, 0, 0, 0);
        check("req046_reuse_idx", 32'(rsp_idx), 26);

        // Free of an unoccupied slot leaves everything alone.
        cycle(0, 0, 1, 10, 0);
        check("req049_cnt", 32'(used_cnt), SPILL ? 9 : 8);
        cycle(1, 1, 0, 0, 0);
        check("req049_idx", 32'(rsp_idx), 8);

        // Twenty slots used, then flush with noise on the inputs.
        do_reset();
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, i, 0, 0, 0);
        check("req047_cnt20", 32'(used_cnt), 20);
        cycle(0, 0, 0, 0, 1);
        check("req047_ready0", 32'(alloc_ready), 0);
        for (int i = 0; i < NR; i++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)));
            check("req047_ready_seq", 32'(alloc_ready), (i == NR - 1) ? 1 : 0);
        end
        check("req047_cnt0", 32'(used_cnt), 0);
        cycle(1, 0, 0, 0, 0);
        check("req047_idx0", 32'(rsp_idx), 0);

        // Allocation and flush together: allocation wins, flush clears it.
        cycle(1, 4, 0, 0, 1);
        check("coincide_idx", 32'(rsp_idx), 32);
        for (int i = 0; i < NR; i++) cycle(0, 0, 0, 0, 0);
        cycle(1, 4, 0, 0, 0);
        check("coincide_reuse", 32'(rsp_idx), 32);

        // Reset during the third flush cycle.
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        check("req048_idx", 32'(rsp_idx), 8);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                  ($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
